// File: rtl/exe_muldiv_iter_pkg.sv
// exe_muldiv_iter_pkg: shared types and constants for the
// iterative RV64M multiply/divide unit.
package exe_muldiv_iter_pkg;

    localparam int MAX_XLEN = 64;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } muldiv_state_t;

    typedef struct packed {
        logic [2:0]          funct3;
        logic                word32;
        logic [MAX_XLEN-1:0] a;
        logic [MAX_XLEN-1:0] b;
    } muldiv_req_t;

    function automatic logic f3_a_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV)  || (f3 == F3_REM);
    endfunction

    function automatic logic f3_b_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) ||
               (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/exe_muldiv_iter_div_step.sv
// exe_muldiv_iter_div_step: DIV_BITS restoring division
// iterations on unsigned magnitudes, purely combinational.
module exe_muldiv_iter_div_step #(
    parameter int XLEN     = 64,
    parameter int DIV_BITS = 1
) (
    input  logic [XLEN-1:0]     rem_i,
    input  logic [DIV_BITS-1:0] dvd_i,
    input  logic [XLEN-1:0]     dsr_i,
    output logic [XLEN-1:0]     rem_o,
    output logic [DIV_BITS-1:0] q_o
);

    logic [XLEN-1:0] r;
    logic [XLEN:0]   t;

    // Shift in one dividend bit per iteration, subtract if it fits
    always_comb begin
        r   = rem_i;
        t   = '0;
        q_o = '0;
        for (int k = 0; k < DIV_BITS; k++) begin
            t = {r, dvd_i[DIV_BITS-1-k]};
            if (t >= {1'b0, dsr_i}) begin
                r = XLEN'(t - {1'b0, dsr_i});
                q_o[DIV_BITS-1-k] = 1'b1;
            end else begin
                r = t[XLEN-1:0];
            end
        end
        rem_o = r;
    end

endmodule

// File: rtl/exe_muldiv_iter.sv
// exe_muldiv_iter: iterative RV64M multiply/divide unit with
// valid/ready request and response ports.
import exe_muldiv_iter_pkg::*;

module exe_muldiv_iter #(
    parameter int XLEN     = 64,
    parameter int MUL_BITS = 4,
    parameter int DIV_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic            req_word32,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam int PW = 2 * XLEN;
    localparam logic [CW-1:0] MUL_N   = CW'(XLEN / MUL_BITS);
    localparam logic [CW-1:0] MUL_N32 = CW'(32 / MUL_BITS);
    localparam logic [CW-1:0] DIV_N   = CW'(XLEN / DIV_BITS);
    localparam logic [CW-1:0] DIV_N32 = CW'(32 / DIV_BITS);

    function automatic logic [XLEN-1:0] ext32(
        input logic [XLEN-1:0] x,
        input logic            s
    );
        logic [XLEN-1:0] r;
        r = x;
        for (int i = 32; i < XLEN; i++) r[i] = s & x[31];
        return r;
    endfunction

    muldiv_state_t   state_q, state_d;
    logic [2:0]      f3_q;
    logic            w32_q, sp_q, qneg_q, rneg_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   acc_q, mcand_q;
    logic [XLEN-1:0] mplier_q, rem_q, dvd_q, dsr_q, res_q;

    muldiv_req_t     req;
    logic            w32_in, a_sgn, b_sgn, a_neg, b_neg;
    logic            b_zero, ovf, special, accept;
    logic [XLEN-1:0] a_in, b_in, a_mag, b_mag, mneg;
    logic [XLEN-1:0] sp_quo, sp_rem;
    logic [PW-1:0]   mcand_in, acc_in, acc_step;
    logic [XLEN-1:0] rem_nx, dvd_nx, quo, q_fix, r_fix;
    logic [XLEN-1:0] div_raw, div_res, mul_low, mul_res, res_d;
    logic [DIV_BITS-1:0] qbits;

    assign req = '{funct3: req_funct3,
                   word32: req_word32,
                   a:      MAX_XLEN'(req_a),
                   b:      MAX_XLEN'(req_b)};

    assign accept = req_ready && req_valid && !flush;

    // Operand conditioning and divide special-case detection
    always_comb begin
        w32_in = req.word32 && (XLEN == 64);
        a_sgn  = f3_a_signed(req.funct3);
        b_sgn  = f3_b_signed(req.funct3);
        a_in   = req.a[XLEN-1:0];
        b_in   = req.b[XLEN-1:0];
        if (w32_in) begin
            a_in = ext32(a_in, a_sgn);
            b_in = ext32(b_in, b_sgn);
        end
        a_neg = a_sgn & a_in[XLEN-1];
        b_neg = b_sgn & b_in[XLEN-1];
        a_mag = a_neg ? -a_in : a_in;
        b_mag = b_neg ? -b_in : b_in;
        mneg  = '0;
        mneg[XLEN-1] = 1'b1;
        if (w32_in) mneg = ext32(XLEN'(32'h8000_0000), 1'b1);
        b_zero  = (b_in == '0);
        ovf     = req.funct3[2] & ~req.funct3[0] &
                  (a_in == mneg) & (&b_in);
        special = req.funct3[2] & (b_zero | ovf);
        sp_quo  = b_zero ? '1 : a_in;
        sp_rem  = b_zero ? a_in : '0;
        if (w32_in) begin
            sp_quo = ext32(sp_quo, 1'b1);
            sp_rem = ext32(sp_rem, 1'b1);
        end
        // Signed multiplier: subtract a<<W once up front
        mcand_in = {{XLEN{a_neg}}, a_in};
        acc_in   = (b_neg && !w32_in) ? -(mcand_in << XLEN) : '0;
    end

    // One multiply step: add MUL_BITS shifted partial products
    always_comb begin
        acc_step = acc_q;
        for (int k = 0; k < MUL_BITS; k++) begin
            if (mplier_q[k]) acc_step = acc_step + (mcand_q << k);
        end
        mul_low = acc_step[XLEN-1:0];
        if (w32_q) mul_res = ext32(mul_low, 1'b1);
        else if (f3_q[1:0] == 2'b00) mul_res = mul_low;
        else mul_res = acc_step[PW-1:XLEN];
    end

    exe_muldiv_iter_div_step #(
        .XLEN     (XLEN),
        .DIV_BITS (DIV_BITS)
    ) u_div_step (
        .rem_i (rem_q),
        .dvd_i (dvd_q[XLEN-1 -: DIV_BITS]),
        .dsr_i (dsr_q),
        .rem_o (rem_nx),
        .q_o   (qbits)
    );

    // Quotient bits shift in as dividend bits shift out
    always_comb begin
        dvd_nx  = {dvd_q[XLEN-1-DIV_BITS:0], qbits};
        quo     = w32_q ? XLEN'(dvd_nx[31:0]) : dvd_nx;
        q_fix   = qneg_q ? -quo : quo;
        r_fix   = rneg_q ? -rem_nx : rem_nx;
        div_raw = f3_q[1] ? r_fix : q_fix;
        if (sp_q) div_res = f3_q[1] ? rem_q : dvd_q;
        else if (w32_q) div_res = ext32(div_raw, 1'b1);
        else div_res = div_raw;
        res_d = f3_q[2] ? div_res : mul_res;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = req.funct3[2] ? DIV : MUL;
            end
            MUL, DIV: begin
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            DONE: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Handshake outputs decoded from state
    always_comb begin
        req_ready  = (state_q == IDLE) && rst;
        busy       = (state_q != IDLE);
        resp_valid = (state_q == DONE);
        resp_data  = res_q;
    end

    // Datapath: load on accept, iterate while MUL/DIV
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f3_q     <= '0;
            w32_q    <= 1'b0;
            sp_q     <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            res_q    <= '0;
        end else if (accept) begin
            f3_q     <= req.funct3;
            w32_q    <= w32_in;
            sp_q     <= special;
            qneg_q   <= a_neg ^ b_neg;
            rneg_q   <= a_neg;
            if (!req.funct3[2]) cnt_q <= w32_in ? MUL_N32 : MUL_N;
            else if (special)   cnt_q <= CW'(1);
            else                cnt_q <= w32_in ? DIV_N32 : DIV_N;
            acc_q    <= acc_in;
            mcand_q  <= mcand_in;
            mplier_q <= b_in;
            rem_q    <= special ? sp_rem : '0;
            if (special)     dvd_q <= sp_quo;
            else if (w32_in) dvd_q <= a_mag << (XLEN - 32);
            else             dvd_q <= a_mag;
            dsr_q    <= b_mag;
        end else if (!flush && (state_q == MUL)) begin
            cnt_q    <= cnt_q - CW'(1);
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << MUL_BITS;
            mplier_q <= mplier_q >> MUL_BITS;
            if (cnt_q == CW'(1)) res_q <= res_d;
        end else if (!flush && (state_q == DIV)) begin
            cnt_q <= cnt_q - CW'(1);
            rem_q <= rem_nx;
            dvd_q <= dvd_nx;
            if (cnt_q == CW'(1)) res_q <= res_d;
        end
    end

endmodule

// File: tb/tb_exe_muldiv_iter.sv
// tb_exe_muldiv_iter: directed vectors with a scoreboard queue
// and an independent response monitor.
import exe_muldiv_iter_pkg::*;

module tb_exe_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = '0;
    logic        req_word32 = 1'b0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_data;
    logic        busy;

    exe_muldiv_iter #(
        .XLEN     (64),
        .MUL_BITS (4),
        .DIV_BITS (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct3 (req_funct3),
        .req_word32 (req_word32),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [63:0] data;
        int          lat;
        int          ipc;
    } exp_t;

    exp_t        sb[$];
    int          pc = 0;
    int          n_pass = 0;
    int          n_tot = 0;
    bit          seen = 1'b0;
    logic [63:0] held = '0;

    always @(posedge clk) pc <= pc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h required 0x%h", nm, act, exp);
    endtask

    // Monitor: compare on first valid, then hold-stability
    always @(negedge clk) begin
        if (rst && resp_valid) begin
            if (!seen) begin
                seen = 1'b1;
                held = resp_data;
                if (sb.size() == 0) begin
                    n_tot++;
                    $display("FAIL unexpected_resp: got 0x%h required none",
                             resp_data);
                end else begin
                    chk({sb[0].nm, "_data"}, resp_data, sb[0].data);
                    chk({sb[0].nm, "_lat"}, 64'(pc - sb[0].ipc),
                        64'(sb[0].lat + 1));
                end
            end else begin
                chk("hold_data", resp_data, held);
                chk("hold_req_ready", 64'(req_ready), 64'd0);
            end
            if (resp_ready) begin
                seen = 1'b0;
                if (sb.size() != 0) void'(sb.pop_front());
            end
        end
    end

    task automatic issue(input string nm, input logic [2:0] f3,
                         input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp,
                         input int lat, input bit track);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk({nm, "_accept_timeout"}, 64'(req_ready), 64'd1);
            return;
        end
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_word32 = w;
        req_a      = a;
        req_b      = b;
        if (track) sb.push_back('{nm, exp, lat, pc});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drain"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        #20 rst = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", 64'(req_ready), 64'd1);

        issue("mul_3x-5", F3_MUL, 0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB,
              64'hFFFF_FFFF_FFFF_FFF1, 16, 1);
        drain("mul_3x-5");
        issue("mulhu_max", F3_MULHU, 0, '1, '1,
              64'hFFFF_FFFF_FFFF_FFFE, 16, 1);
        drain("mulhu_max");
        issue("mulhsu_m1x2", F3_MULHSU, 0, '1, 64'd2, '1, 16, 1);
        drain("mulhsu_m1x2");
        issue("mulh_m1xm1", F3_MULH, 0, '1, '1, 64'd0, 16, 1);
        drain("mulh_m1xm1");
        issue("mulw", F3_MUL, 1, 64'h1234_5678_7FFF_FFFF, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFE, 8, 1);
        drain("mulw");

        issue("divw_ovf", F3_DIV, 1, 64'h0000_0000_8000_0000, '1,
              64'hFFFF_FFFF_8000_0000, 1, 1);
        drain("divw_ovf");
        issue("remu_by0", F3_REMU, 0, 64'd7, 64'd0, 64'd7, 1, 1);
        drain("remu_by0");
        issue("divu_by0", F3_DIVU, 0, 64'd100, 64'd0, '1, 1, 1);
        drain("divu_by0");
        issue("rem_ovf", F3_REM, 0, 64'h8000_0000_0000_0000, '1,
              64'd0, 1, 1);
        drain("rem_ovf");

        issue("div_m7_2", F3_DIV, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFD, 64, 1);
        drain("div_m7_2");
        issue("divw_m7_2", F3_DIV, 1, 64'h0000_0000_FFFF_FFF9, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFD, 32, 1);
        drain("divw_m7_2");

        resp_ready = 1'b0;
        issue("rem_m7_2", F3_REM, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
              '1, 64, 1);
        begin
            int n = 0;
            while (!resp_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("rem_m7_2_valid_seen", 64'(resp_valid), 64'd1);
        end
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 resp_ready = 1'b1;
        drain("rem_m7_2");

        issue("div_flushed", F3_DIV, 0, 64'd1000, 64'd3, 64'd0, 64, 0);
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_resp_valid", 64'(resp_valid), 64'd0);
        chk("flush_req_ready", 64'(req_ready), 64'd1);
        repeat (80) @(negedge clk);
        issue("mul_6x7", F3_MUL, 0, 64'd6, 64'd7, 64'd42, 16, 1);
        drain("mul_6x7");

        issue("mul_reset", F3_MUL, 0, 64'd5, 64'd5, 64'd25, 16, 0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_resp_valid", 64'(resp_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_req_ready", 64'(req_ready), 64'd0);
        chk("arst_resp_data", resp_data, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", 64'(req_ready), 64'd1);
        chk("post_rst_busy", 64'(busy), 64'd0);
        issue("divu_100_7", F3_DIVU, 0, 64'd100, 64'd7, 64'd14, 64, 1);
        drain("divu_100_7");
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
